// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
   localparam int INSTR_W = 32;
   localparam int PC_STEP = 4;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [31:0]        pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Shift-register FIFO of fetched {instr, pc}; the head is always entry 0, so the
// consumer sees plain register outputs. Flush wins over push.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  fetch_entry_t  push_data_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output logic [CW-1:0] count_o,
   output logic          valid_o,
   output fetch_entry_t  head_o
);
   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [CW-1:0] count_q, count_d;
   logic          valid_q;

   always_comb begin
      mem_d   = mem_q;
      count_d = count_q;
      if (flush_i) begin
         count_d = '0;
      end else begin
         if (pop_i) begin
            for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i + 1];
            count_d = count_q - 1'b1;
         end
         // The new word lands in the first slot left free after the pop.
         if (push_i) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (count_d == CW'(i)) mem_d[i] = push_data_i;
            end
            count_d = count_d + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
         count_q <= count_d;
         valid_q <= (count_d != '0);
      end
   end

   assign count_o = count_q;
   assign valid_o = valid_q;
   assign head_o  = mem_q[0];
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word addresses to a synchronous
// instruction memory, and buffers tagged responses for decode.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [31:0]        imem_addr,
   input  logic [INSTR_W-1:0] imem_instr,
   input  logic               br_valid,
   input  logic [31:0]        br_target,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [INSTR_W-1:0] if_instr,
   output logic [31:0]        if_pc
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   infl_pc_q, infl_pc_d;
   logic          infl_q, infl_d;
   logic [31:0]   issue_addr;
   logic          issue;
   logic          pop;
   logic [CW-1:0] fifo_count;
   logic          fifo_valid;
   fetch_entry_t  fifo_head;
   fetch_entry_t  push_entry;

   assign pop        = fifo_valid & if_ready;
   assign issue_addr = br_valid ? (br_target & ~32'h3) : pc_q;
   assign imem_addr  = {2'b00, issue_addr[31:2]};

   // Credit check: buffered plus in-flight words may never exceed the FIFO.
   // A redirect discards both, so it always has room to issue.
   assign issue = br_valid |
                  ((32'(fifo_count) + 32'(infl_q)) < (32'(FIFO_DEPTH) + 32'(pop)));

   always_comb begin
      pc_d      = pc_q;
      infl_pc_d = infl_pc_q;
      infl_d    = issue;
      if (issue) begin
         pc_d      = issue_addr + 32'(PC_STEP);
         infl_pc_d = issue_addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         infl_pc_q <= '0;
         infl_q    <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         infl_pc_q <= infl_pc_d;
         infl_q    <= infl_d;
      end
   end

   assign push_entry.instr = imem_instr;
   assign push_entry.pc    = infl_pc_q;

   // A wrong-path response arriving during a redirect is dropped by the flush.
   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (infl_q),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .flush_i     (br_valid),
      .count_o     (fifo_count),
      .valid_o     (fifo_valid),
      .head_o      (fifo_head)
   );

   assign if_valid = fifo_valid;
   assign if_instr = fifo_head.instr;
   assign if_pc    = fifo_head.pc;
endmodule
